// File: rtl/syn_global_pkg.sv
// rtl/syn_global_pkg.sv - shared datapath widths
package syn_global_pkg;

    localparam int P_32B_W = 32;
    localparam int P_16B_W = 16;

endpackage

// File: rtl/syn_gpu_pkg.sv
// rtl/syn_gpu_pkg.sv - multiplier ID codes and arbiter FSM states
package syn_gpu_pkg;

    localparam int MID_W = 4;

    typedef logic [MID_W-1:0] mid_t;

    localparam mid_t MID_IDLE = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT_RSP
    } arb_state_e;

    // Client k is tagged k+1 so that MID_IDLE never appears on an issued request.
    function automatic mid_t client_mid(input int unsigned k);
        return mid_t'(k + 1);
    endfunction

endpackage

// File: rtl/syn_rr_arb.sv
// rtl/syn_rr_arb.sv - round-robin pick among N requests, pointer holds last grant
module syn_rr_arb #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_ir,
    input  logic             rst_sync,
    input  logic [N-1:0]     req,
    input  logic             take,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;

    // Search order is last-granted+1 upward, so the last winner is checked last.
    always_comb begin
        any  = 1'b0;
        idx  = ptr_q;
        cand = ptr_q;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        ptr_d = take ? idx : ptr_q;
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/syn_gpu_mul_arb.sv
// rtl/syn_gpu_mul_arb.sv - round-robin arbiter sharing one tagged multiplier between clients
module syn_gpu_mul_arb
    import syn_global_pkg::*;
    import syn_gpu_pkg::*;
#(
    parameter int P_NUM_CLIENTS = 3,
    parameter int P_TIMEOUT     = 32
) (
    input  logic                                  clk_ir,
    input  logic                                  rst_sync,
    input  logic [P_NUM_CLIENTS-1:0]              cl_req_valid,
    input  logic [P_NUM_CLIENTS-1:0][P_32B_W-1:0] cl_req_data,
    output logic [P_NUM_CLIENTS-1:0]              cl_req_ready,
    output logic [P_NUM_CLIENTS-1:0]              cl_rsp_valid,
    output logic [P_32B_W-1:0]                    cl_rsp_data,
    output mid_t                                  mul_req_mid,
    output logic [P_32B_W-1:0]                    mul_req_data,
    input  logic                                  mul_busy,
    input  mid_t                                  mul_rsp_mid,
    input  logic [P_32B_W-1:0]                    mul_rsp_data,
    output logic                                  arb_err
);

    localparam int IDX_W = (P_NUM_CLIENTS > 1) ? $clog2(P_NUM_CLIENTS) : 1;
    localparam int TMO_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           gnt_q, gnt_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic [P_NUM_CLIENTS-1:0]   cl_req_ready_q, cl_req_ready_d;
    logic [P_NUM_CLIENTS-1:0]   cl_rsp_valid_q, cl_rsp_valid_d;
    logic [P_32B_W-1:0]         cl_rsp_data_q, cl_rsp_data_d;
    mid_t                       mul_req_mid_q, mul_req_mid_d;
    logic [P_32B_W-1:0]         mul_req_data_q, mul_req_data_d;
    logic                       arb_err_q, arb_err_d;

    logic                       arb_any;
    logic [IDX_W-1:0]           arb_idx;
    logic                       arb_take;
    logic                       rsp_hit;

    syn_rr_arb #(
        .N     (P_NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .clk_ir   (clk_ir),
        .rst_sync (rst_sync),
        .req      (cl_req_valid),
        .take     (arb_take),
        .any      (arb_any),
        .idx      (arb_idx)
    );

    assign rsp_hit = (mul_rsp_mid != MID_IDLE);

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        tmo_d          = tmo_q;
        cl_req_ready_d = '0;
        cl_rsp_valid_d = '0;
        cl_rsp_data_d  = cl_rsp_data_q;
        mul_req_mid_d  = MID_IDLE;
        mul_req_data_d = '0;
        arb_err_d      = arb_err_q;
        arb_take       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any && !mul_busy) begin
                    arb_take                = 1'b1;
                    gnt_d                   = arb_idx;
                    cl_req_ready_d[arb_idx] = 1'b1;
                    mul_req_mid_d           = client_mid(32'(arb_idx));
                    mul_req_data_d          = cl_req_data[arb_idx];
                    state_d                 = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_ARM;
            end
            // The multiplier shows a stale MID right after a request, so ARM only watches busy.
            ST_ARM: begin
                if (mul_busy) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_hit) begin
                    cl_rsp_valid_d[gnt_q] = 1'b1;
                    cl_rsp_data_d         = mul_rsp_data;
                    if (mul_rsp_mid != client_mid(32'(gnt_q))) begin
                        arb_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A response in the final budget cycle still wins over the abort.
        if (state_q == ST_ARM || (state_q == ST_WAIT_RSP && !rsp_hit)) begin
            if (tmo_q == TMO_W'(P_TIMEOUT - 1)) begin
                state_d   = ST_IDLE;
                arb_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state_q        <= ST_IDLE;
            gnt_q          <= '0;
            tmo_q          <= '0;
            cl_req_ready_q <= '0;
            cl_rsp_valid_q <= '0;
            cl_rsp_data_q  <= '0;
            mul_req_mid_q  <= MID_IDLE;
            mul_req_data_q <= '0;
            arb_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            tmo_q          <= tmo_d;
            cl_req_ready_q <= cl_req_ready_d;
            cl_rsp_valid_q <= cl_rsp_valid_d;
            cl_rsp_data_q  <= cl_rsp_data_d;
            mul_req_mid_q  <= mul_req_mid_d;
            mul_req_data_q <= mul_req_data_d;
            arb_err_q      <= arb_err_d;
        end
    end

    assign cl_req_ready = cl_req_ready_q;
    assign cl_rsp_valid = cl_rsp_valid_q;
    assign cl_rsp_data  = cl_rsp_data_q;
    assign mul_req_mid  = mul_req_mid_q;
    assign mul_req_data = mul_req_data_q;
    assign arb_err      = arb_err_q;

endmodule
